// File: rtl/l2_cache_control_pkg.sv
// Shared types for the L2 cache control slice.
//   l2_ctrl_state_t : control FSM state encoding, also driven out on the
//                     debug state port of l2_cache_control.
package lc3b_types;

  typedef enum logic [1:0] {
    L2_IDLE      = 2'd0,
    L2_WRITEBACK = 2'd1,
    L2_ALLOCATE  = 2'd2
  } l2_ctrl_state_t;

endpackage

// File: rtl/l2_cache_control_sat_counter.sv
// Saturating up-counter used for the L2 performance counters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one this cycle (ignored once the count is all-ones)
//   clear      : synchronous clear, takes precedence over inc
//   count      : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the 4-way L2 cache datapath.
// Sequences lookup, dirty-victim writeback, line allocation and pseudo-LRU
// update between the L1 requester and physical memory, and keeps saturating
// hit/miss/writeback counters plus a sticky pmem watchdog.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   mem_read, mem_write   : L1 request, held until mem_resp (write has priority)
//   mem_resp              : one-cycle completion pulse to L1 (IDLE only)
//   hit, full, dirty      : datapath lookup status for the current index
//   write, valid_in, dirty_in, pseudoarray_load : datapath array controls
//   pmem_addressmuxsel    : 0 = request tag (fill), 1 = victim tag (writeback)
//   pmem_read, pmem_write : physical memory strobes, held until pmem_resp
//   pmem_resp             : physical memory completion pulse
//   count_clear           : synchronous clear of all counters
//   hit_count, miss_count, wb_count : saturating performance counters
//   err_timeout           : sticky watchdog error, cleared only by rst_n
//   state_dbg             : current FSM state
// Handshake: the L1 side holds mem_read/mem_write until a cycle where
// mem_resp is high; the memory side sees pmem_read/pmem_write held until a
// cycle where pmem_resp is high. Transfers complete in the cycle the
// response is high.
module l2_cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 hit,
  input  logic                 full,
  input  logic                 dirty,
  output logic                 write,
  output logic                 valid_in,
  output logic                 dirty_in,
  output logic                 pseudoarray_load,
  output logic                 pmem_addressmuxsel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 count_clear,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count,
  output logic                 err_timeout,
  output l2_ctrl_state_t       state_dbg
);

  // One extra code point so the watchdog can park at TIMEOUT_CYCLES.
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

  l2_ctrl_state_t  state;
  logic            refill;   // set on a miss: the next IDLE hit is the post-fill service
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  logic req;
  logic hit_inc, miss_inc, wb_inc;

  assign req = mem_read | mem_write;

  assign hit_inc  = (state == L2_IDLE) && req && hit && !refill;
  assign miss_inc = (state == L2_IDLE) && req && !hit;
  assign wb_inc   = (state == L2_WRITEBACK) && pmem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= L2_IDLE;
      refill <= 1'b0;
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        L2_IDLE: begin
          wd_cnt <= '0;
          if (req) begin
            if (hit) begin
              refill <= 1'b0;
            end else begin
              refill <= 1'b1;
              state  <= (full && dirty) ? L2_WRITEBACK : L2_ALLOCATE;
            end
          end else begin
            // Requester gave up mid-miss; forget the pending service hit.
            refill <= 1'b0;
          end
        end
        L2_WRITEBACK, L2_ALLOCATE: begin
          if (pmem_resp) begin
            wd_cnt <= '0;
            state  <= (state == L2_WRITEBACK) ? L2_ALLOCATE : L2_IDLE;
          end else begin
            if (wd_cnt == WD_LAST) err_q <= 1'b1;
            if (wd_cnt != WD_MAX)  wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= L2_IDLE;
      endcase
    end
  end

  // Outputs decode from state; the hit path also depends on the live
  // request so a hit is served in the same cycle it is presented.
  always_comb begin
    mem_resp           = 1'b0;
    write              = 1'b0;
    valid_in           = 1'b0;
    dirty_in           = 1'b0;
    pseudoarray_load   = 1'b0;
    pmem_addressmuxsel = 1'b0;
    pmem_read          = 1'b0;
    pmem_write         = 1'b0;
    case (state)
      L2_IDLE: begin
        if (req && hit) begin
          mem_resp         = 1'b1;
          pseudoarray_load = 1'b1;
          if (mem_write) begin
            write    = 1'b1;
            valid_in = 1'b1;
            dirty_in = 1'b1;
          end
        end
      end
      L2_WRITEBACK: begin
        pmem_write         = 1'b1;
        pmem_addressmuxsel = 1'b1;
      end
      L2_ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          // Fill lands clean in the LRU way.
          write    = 1'b1;
          valid_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign err_timeout = err_q;
  assign state_dbg   = state;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .clear (count_clear),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .clear (count_clear),
    .count (miss_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wb_inc),
    .clear (count_clear),
    .count (wb_count)
  );

endmodule
